// File: rtl/div_seq_pkg.sv
// Shared definitions for the execute-stage divide sequencer: bus types, state
// encodings, handshake levels and the reset level of this clock domain.
package div_seq_pkg;

   localparam int RegWidth = 32;

   typedef logic [RegWidth-1:0]   RegBus;
   typedef logic [2*RegWidth-1:0] DoubleRegBus;

   localparam RegBus ZeroWord = '0;

   localparam logic [1:0] DivFree   = 2'b00;
   localparam logic [1:0] DivByZero = 2'b01;
   localparam logic [1:0] DivOn     = 2'b10;
   localparam logic [1:0] DivEnd    = 2'b11;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   localparam logic DivStart = 1'b1;
   localparam logic DivStop  = 1'b0;

   // This domain resets on a low level.
   localparam logic RstEnable = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Radix-2 shift-subtract divider: result 33 cycles after accept (2 for divide-by-zero),
// held while start_i stays high; stall_req_o holds the pipeline while the divide runs.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int DATA_W = RegWidth
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o,
   output logic                stall_req_o
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   logic [1:0]          state;
   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W:0]   work;
   logic [DATA_W-1:0]   divisor;
   logic                neg_dividend;
   logic                neg_divisor;

   logic                accept;
   logic [DATA_W-1:0]   dividend_mag;
   logic [DATA_W-1:0]   divisor_mag;
   logic [2*DATA_W:0]   shifted;
   logic [DATA_W:0]     diff;
   logic [2*DATA_W:0]   work_nxt;
   logic [DATA_W-1:0]   quo;
   logic [DATA_W-1:0]   rem;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   assign accept = (state == DivFree) && (start_i == DivStart) && !annul_i;

   assign dividend_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
   assign divisor_mag  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

   // Partial remainder is always below the divisor, so the top bit of work is
   // zero before each shift and the 33-bit difference sign is exact.
   assign shifted  = work << 1;
   assign diff     = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
   assign work_nxt = diff[DATA_W] ? shifted
                                  : {diff, shifted[DATA_W-1:1], 1'b1};

   assign quo     = work_nxt[DATA_W-1:0];
   assign rem     = work_nxt[2*DATA_W-1:DATA_W];
   assign quo_fix = (neg_dividend ^ neg_divisor) ? -quo : quo;
   assign rem_fix = neg_dividend ? -rem : rem;

   // Gated by reset so every output reads zero the moment reset asserts.
   assign stall_req_o = (rst != RstEnable) &&
                        (accept || (state == DivOn) || (state == DivByZero));

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         state        <= DivFree;
         cnt          <= '0;
         work         <= '0;
         divisor      <= '0;
         neg_dividend <= 1'b0;
         neg_divisor  <= 1'b0;
         result_o     <= '0;
         ready_o      <= DivResultNotReady;
      end else begin
         case (state)
            DivFree: begin
               if (accept) begin
                  neg_dividend <= signed_div_i & opdata1_i[DATA_W-1];
                  neg_divisor  <= signed_div_i & opdata2_i[DATA_W-1];
                  divisor      <= divisor_mag;
                  work         <= {{(DATA_W+1){1'b0}}, dividend_mag};
                  cnt          <= '0;
                  state        <= (opdata2_i == '0) ? DivByZero : DivOn;
               end
            end
            DivByZero: begin
               if (annul_i) begin
                  state <= DivFree;
               end else begin
                  result_o <= '0;
                  ready_o  <= DivResultReady;
                  state    <= DivEnd;
               end
            end
            DivOn: begin
               if (annul_i) begin
                  state <= DivFree;
               end else begin
                  work <= work_nxt;
                  cnt  <= cnt + 1'b1;
                  if (cnt == LAST_CNT) begin
                     result_o <= {rem_fix, quo_fix};
                     ready_o  <= DivResultReady;
                     state    <= DivEnd;
                  end
               end
            end
            DivEnd: begin
               if (annul_i || (start_i == DivStop)) begin
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
                  state    <= DivFree;
               end
            end
            default: state <= DivFree;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: results, handshake timing, stall window, annul and async reset.
module tb_div_seq;
   import div_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stall_req_o;

   int checks = 0;
   int errors = 0;

   div_seq #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stall_req_o  (stall_req_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; that cycle is T0. Waits for ready with a cycle budget.
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat, input string tag);
      int lat;
      int stalls;
      bit got;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      #1;
      stalls = stall_req_o ? 1 : 0;
      lat    = 0;
      got    = 1'b0;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         if (ready_o) got = 1'b1;
         else if (stall_req_o) stalls++;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat));
      check({tag, " result"}, result_o, exp);
      check({tag, " stall in ready cycle"}, 64'(stall_req_o), 64'd0);
      @(negedge clk);
      check({tag, " ready held"}, 64'({ready_o, result_o == exp}), 64'd3);
      start_i = 1'b0;
      @(negedge clk);
      check({tag, " ready drop"}, 64'(ready_o), 64'd0);
      check({tag, " result clear"}, result_o, 64'd0);
      @(negedge clk);
   endtask

   initial begin
      int rose;
      rst          = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      repeat (2) @(negedge clk);
      check("reset result", result_o, 64'd0);
      check("reset ready", 64'(ready_o), 64'd0);
      check("reset stall", 64'(stall_req_o), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("idle stall", 64'(stall_req_o), 64'd0);

      run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, "u 100/7");
      run_div(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33, "s -100/7");
      run_div(1'b1, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 33, "s 100/-7");
      run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33, "s -100/-7");
      run_div(1'b0, 32'h12345678, 32'd0, 64'd0, 2, "u div0");
      run_div(1'b1, 32'h12345678, 32'd0, 64'd0, 2, "s div0");
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, "s overflow");
      run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, "u max/1");
      run_div(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33, "u max/16");
      run_div(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 33, "u max/max");

      // start and annul together in DivFree must not accept
      opdata1_i = 32'd20;
      opdata2_i = 32'd4;
      start_i   = 1'b1;
      annul_i   = 1'b1;
      #1;
      check("annul+start stall", 64'(stall_req_o), 64'd0);
      repeat (3) @(negedge clk);
      check("annul+start state", 64'(dut.state), 64'(DivFree));
      check("annul+start ready", 64'(ready_o), 64'd0);
      start_i = 1'b0;
      annul_i = 1'b0;
      @(negedge clk);

      // annul in the middle of a divide
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      repeat (10) @(negedge clk);
      check("pre-annul stall", 64'(stall_req_o), 64'd1);
      annul_i = 1'b1;
      @(negedge clk);
      check("annul state", 64'(dut.state), 64'(DivFree));
      check("annul stall", 64'(stall_req_o), 64'd0);
      start_i = 1'b0;
      annul_i = 1'b0;
      rose = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready_o || stall_req_o) rose++;
      end
      check("annul quiet", 64'(rose), 64'd0);
      run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, "u 9/3 after annul");

      // asynchronous reset mid-divide
      opdata1_i = 32'd1000;
      opdata2_i = 32'd7;
      start_i   = 1'b1;
      repeat (20) @(negedge clk);
      check("pre-reset stall", 64'(stall_req_o), 64'd1);
      rst = 1'b0;
      #1;
      check("async reset outputs", {result_o[62:0], ready_o | stall_req_o}, 64'd0);
      check("async reset result top", 64'(result_o[63]), 64'd0);
      check("async reset state", 64'(dut.state), 64'(DivFree));
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_div(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 33, "u 50/5 after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle 32-bit divide sequencer for the execute stage. Accepts a signed or unsigned divide request from `ex`, runs a 32-iteration radix-2 shift-subtract, and returns a 64-bit {remainder, quotient} with a one-level ready handshake. While busy it raises a stall request to the pipeline controller. It honours pipeline annul so a flushed divide never writes back.

## Interface
- `DATA_W`, 32, operand width; iteration count equals `DATA_W`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `signed_div_i` in 1: 1 = two's-complement divide, 0 = unsigned.
- `opdata1_i` in DATA_W: dividend; sampled only on accept.
- `opdata2_i` in DATA_W: divisor; sampled only on accept.
- `start_i` in 1: request; held high by `ex` until it sees `ready_o`.
- `annul_i` in 1: flush; abandons any operation in progress.
- `result_o` out 2*DATA_W: {remainder[63:32], quotient[31:0]}; valid only while `ready_o`.
- `ready_o` out 1: result valid.
- `stall_req_o` out 1: request pipeline stall.

## Operation
- States: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
- `DivFree`: on `start_i & !annul_i`, latch operands.
  - Divisor 0 → `DivByZero`.
  - Otherwise → `DivOn` with `cnt=0`.
  - When `signed_div_i`, latch the magnitude of each negative operand (two's complement) and record both sign bits.
- `DivOn`: one iteration per cycle on a 65-bit working register (upper half = partial remainder, lower half = dividend/quotient).
  - Shift left 1.
  - Subtract divisor from the upper 33 bits.
  - If the result is non-negative, take it and set quotient LSB = 1. Otherwise keep the shifted value, LSB = 0.
  - `cnt` increments; after iteration 31 → `DivEnd`.
  - `annul_i` high in any cycle → `DivFree`, result discarded.
- `DivByZero`: result forced to 0 → `DivEnd` next cycle.
- `DivEnd` sign fix-up, signed only:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - `ready_o=1`, `result_o` holds the value.
  - Stay until `start_i` drops, then → `DivFree` with `ready_o=0` and `result_o=0`.
  - `annul_i` in `DivEnd` → `DivFree`.
- `stall_req_o` = (`DivFree & start_i & !annul_i`) | `DivOn` | `DivByZero`. Combinational; low in `DivEnd`, so `ex` advances in the ready cycle.
- Overflow 0x80000000 / −1 (signed) wraps: quotient 0x80000000, remainder 0, no trap.
- Reset (any state, any time): state `DivFree`, `cnt=0`, working register 0, `result_o=0`, `ready_o=0`. `stall_req_o=0` until `start_i` is next seen.

## Timing
- Accept edge T0. `DivOn` occupies T1..T32. `ready_o` goes high at T33 (33 cycles after accept).
- Divide by zero: accept T0, `DivByZero` T1, `ready_o` high at T2.
- `ready_o` stays high for as long as `start_i` stays high. It drops one cycle after `start_i` falls.
- A new request needs at least one cycle in `DivFree`; no back-to-back accept from `DivEnd`.
- Annul takes effect at the next edge; the state is `DivFree` one cycle after `annul_i` is asserted.
- `annul_i` and `start_i` both high in `DivFree` → no accept.

## Structure
- The shared defines file gets:
  - the state encodings;
  - `DivResultReady` / `DivResultNotReady`;
  - `DivStart` / `DivStop`;
  - `RstEnable` redefined as `1'b0` for this clock domain.
- Reuse `RegBus`, `DoubleRegBus` and `ZeroWord`.
- Single module. The 33-bit subtract stays inline; no sub-module warranted.

## Test plan
- Unsigned 100 / 7 → at T33, `result_o` = {0x00000002, 0x0000000E}, `ready_o=1`; `stall_req_o` high T0..T32.
- Signed −100 / 7 → {0xFFFFFFFE, 0xFFFFFFF2}. Signed 100 / −7 → {0x00000002, 0xFFFFFFF2}.
- 0x12345678 / 0 (either mode) → `ready_o` at T2, `result_o` = 0. Stall high T0..T1 only.
- Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Annul at T10:
  - required: `DivFree` at T11, `ready_o` never rises, `stall_req_o` low from T11;
  - follow-up request 9 / 3 → {0, 3} at its own T33.
- Assert `rst` low at T20 → all outputs 0 at once (asynchronous). After release, a fresh 50 / 5 gives {0, 0x0000000A} after 33 cycles.
